dm_responder: RTL and testbench



---
 rtl/dm_responder.sv | 185 ++++++++++++++++++
 tb/tb_dm_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder - responder end of the CPU data-memory handshake interface.
//
// Accepts one load/store at a time on the request channel, performs the
// access against word-organised storage a fixed number of cycles later and
// presents the result on the response channel until it is consumed.
// Committed stores are logged as "@<pc>: *<addr> <= <word>".
//
// Parameters
//   DEPTH    number of 32-bit words (byte range 0 .. DEPTH*4-1)
//   LATENCY  cycles from request accept to response valid (1..15)
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  responder idle, request can be taken
//   req_we      in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   lane-aligned store data
//   req_byteen  in   store lane enables
//   req_pc      in   issuing PC, used only for the write trace
//   resp_valid  out  response present
//   resp_ready  in   requester consumes the response
//   resp_rdata  out  load data, 0 for stores and errors
//   resp_err    out  request misaligned or out of range
module dm_responder #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_byteen;
    logic [31:0] r_pc;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic             w_accept;
    logic             w_access;
    logic             w_we;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic [3:0]       w_byteen;
    logic [31:0]      w_pc;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_old;
    logic [31:0]      w_merged;
    logic             w_commit;

    assign w_accept = (r_state == IDLE) && req_valid;

    // With LATENCY==1 the access happens on the accept edge itself, so the
    // live request inputs feed the access; otherwise the latched copy does.
    assign w_access = (w_accept && (LATENCY == 1)) ||
                      ((r_state == WAIT) && (r_cnt == 4'd1));

    assign w_we     = (r_state == IDLE) ? req_we     : r_we;
    assign w_addr   = (r_state == IDLE) ? req_addr   : r_addr;
    assign w_wdata  = (r_state == IDLE) ? req_wdata  : r_wdata;
    assign w_byteen = (r_state == IDLE) ? req_byteen : r_byteen;
    assign w_pc     = (r_state == IDLE) ? req_pc     : r_pc;

    assign w_err    = (w_addr[1:0] != 2'b00) || (w_addr >= BYTE_LIMIT);
    assign w_idx    = w_addr[IDX_W+1:2];
    assign w_old    = r_mem[w_idx];
    assign w_commit = w_access && w_we && !w_err && (w_byteen != 4'b0000);

    always_comb begin
        w_merged = w_old;
        for (int unsigned b = 0; b < 4; b++) begin
            if (w_byteen[b]) begin
                w_merged[8*b +: 8] = w_wdata[8*b +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (req_valid)       w_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (r_cnt == 4'd1)   w_next = RESP;
            RESP: if (resp_ready)      w_next = IDLE;
            default:                   w_next = IDLE;
        endcase
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // Request latch, latency counter and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_byteen <= '0;
            r_pc     <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_byteen <= req_byteen;
                r_pc     <= req_pc;
                r_cnt    <= CNT_INIT;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? '0 : w_old;
            end else if ((r_state == RESP) && resp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    // Word storage, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

`ifndef SYNTHESIS
    // Write trace, simulation only
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            $display("@%08h: *%08h <= %08h", w_pc, w_addr, w_merged);
        end
    end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: instance 0 uses LATENCY=2, instance 1 LATENCY=1.
// A transaction-level model predicts req_ready/resp_* every cycle; directed
// sequences add literal expectations.
module tb_dm_responder;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_byteen [2];
    logic [31:0] req_pc     [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    dm_responder #(.DEPTH(4096), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_byteen(req_byteen[0]),
        .req_pc(req_pc[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dm_responder #(.DEPTH(4096), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_byteen(req_byteen[1]),
        .req_pc(req_pc[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int edge_n = 0;

    always @(posedge clk) edge_n++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_busy  [2];
    bit          m_valid [2];
    bit          m_err   [2];
    int          m_left  [2];
    bit [31:0]   m_rdata [2];
    bit          m_qwe   [2];
    bit [31:0]   m_qaddr [2];
    bit [31:0]   m_qdata [2];
    bit [3:0]    m_qbe   [2];
    bit [31:0]   m_mem   [2][4096];

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic m_commit(input int k);
        bit bad;
        bad = (m_qaddr[k][1:0] != 2'b00) || (m_qaddr[k] >= 32'd16384);
        m_valid[k] = 1'b1;
        m_err[k]   = bad;
        m_rdata[k] = '0;
        if (!bad) begin
            if (m_qwe[k]) begin
                for (int b = 0; b < 4; b++)
                    if (m_qbe[k][b]) m_mem[k][m_qaddr[k] >> 2][8*b +: 8] = m_qdata[k][8*b +: 8];
            end else begin
                m_rdata[k] = m_mem[k][m_qaddr[k] >> 2];
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 0; m_valid[k] = 0; m_err[k] = 0; m_rdata[k] = '0;
                for (int i = 0; i < 4096; i++) m_mem[k][i] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_valid[k]) begin
                    if (resp_ready[k]) begin
                        m_valid[k] = 0;
                        m_busy[k]  = 0;
                    end
                end else if (m_busy[k]) begin
                    m_left[k]--;
                    if (m_left[k] == 0) m_commit(k);
                end else if (req_valid[k]) begin
                    m_busy[k]  = 1;
                    m_qwe[k]   = req_we[k];
                    m_qaddr[k] = req_addr[k];
                    m_qdata[k] = req_wdata[k];
                    m_qbe[k]   = req_byteen[k];
                    m_left[k]  = lat(k) - 1;
                    if (m_left[k] == 0) m_commit(k);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("req_ready%0d", k),  32'(req_ready[k]),  32'(!m_busy[k]));
                check($sformatf("resp_valid%0d", k), 32'(resp_valid[k]), 32'(m_valid[k]));
                check($sformatf("resp_rdata%0d", k), resp_rdata[k],      m_valid[k] ? m_rdata[k] : 32'h0);
                check($sformatf("resp_err%0d", k),   32'(resp_err[k]),   32'(m_valid[k] & m_err[k]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input int k, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] pc);
        int i;
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
        req_wdata[k] = wdata; req_byteen[k] = be; req_pc[k] = pc;
        i = 0;
        while (!req_ready[k]) begin
            @(negedge clk);
            i++;
            if (i > 40) begin
                checks++; errors++;
                $display("FAIL accept_timeout dut%0d: waited %0d cycles, required < 40", k, i);
                break;
            end
        end
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    // Waits for the response, captures it, then completes the handshake.
    task automatic collect(input int k, output logic [31:0] rdata, output logic err);
        int i;
        i = 0;
        while (!resp_valid[k]) begin
            @(negedge clk);
            i++;
            if (i > 40) begin
                checks++; errors++;
                $display("FAIL resp_timeout dut%0d: waited %0d cycles, required < 40", k, i);
                break;
            end
        end
        rdata = resp_rdata[k];
        err   = resp_err[k];
        resp_ready[k] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required earlier finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          acc [4];
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_exp  [4];

        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_we[k] = 0; req_addr[k] = '0; req_wdata[k] = '0;
            req_byteen[k] = '0; req_pc[k] = '0; resp_ready[k] = 1'b1;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_req_ready",  32'(req_ready[0]),  32'd1);
        check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_resp_rdata", resp_rdata[0],      32'h0);
        check("rst_resp_err",   32'(resp_err[0]),   32'd0);

        // Full store, then latency of LATENCY=2
        issue(0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 32'h0000_3000);
        check("st_valid_edge1", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        check("st_valid_edge2", 32'(resp_valid[0]), 32'd1);
        collect(0, rd, er);
        check("st_rdata", rd, 32'h0);
        check("st_err",   32'(er), 32'd0);

        issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0000_3004);
        collect(0, rd, er);
        check("ld_full", rd, 32'h1234_5678);

        // Partial store to lane 1
        issue(0, 1'b1, 32'h0000_0010, 32'h0000_AB00, 4'b0010, 32'h0000_3008);
        collect(0, rd, er);
        issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0000_300C);
        collect(0, rd, er);
        check("ld_partial", rd, 32'h1234_AB78);
        check("model_word", m_mem[0][4], 32'h1234_AB78);

        // Store with no lanes enabled changes nothing
        issue(0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0000_3010);
        collect(0, rd, er);
        check("be0_err", 32'(er), 32'd0);
        issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0000_3014);
        collect(0, rd, er);
        check("ld_after_be0", rd, 32'h1234_AB78);

        // Backpressure with a competing request held on the bus
        resp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0000_3018);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h0000_0014;
        for (int i = 0; i < 5 && !resp_valid[0]; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(resp_valid[0]), 32'd1);
            check("bp_rdata", resp_rdata[0],      32'h1234_AB78);
            check("bp_ready", 32'(req_ready[0]),  32'd0);
            @(negedge clk);
        end
        resp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_idle_after_hs", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        check("bp_accepted_next", 32'(req_ready[0]), 32'd0);
        req_valid[0] = 1'b0;
        collect(0, rd, er);
        check("bp_second_rdata", rd, 32'h0);

        // Error cases and the last legal word
        issue(0, 1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF, 32'h0000_3020);
        collect(0, rd, er);
        check("misalign_err",   32'(er), 32'd1);
        check("misalign_rdata", rd,      32'h0);
        issue(0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 32'h0000_3024);
        collect(0, rd, er);
        check("range_err",   32'(er), 32'd1);
        check("range_rdata", rd,      32'h0);
        issue(0, 1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 4'hF, 32'h0000_3028);
        collect(0, rd, er);
        issue(0, 1'b0, 32'h0000_3FFC, 32'h0, 4'h0, 32'h0000_302C);
        collect(0, rd, er);
        check("last_word_rdata", rd, 32'hCAFE_F00D);
        check("last_word_err",   32'(er), 32'd0);
        issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0000_3030);
        collect(0, rd, er);
        check("unchanged_after_err", rd, 32'h1234_AB78);

        // Reset during WAIT of a store
        issue(0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 32'h0000_3034);
        #2 reset = 1'b1;
        #1;
        check("midrst_req_ready",  32'(req_ready[0]),  32'd1);
        check("midrst_resp_valid", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("postrst_resp_valid", 32'(resp_valid[0]), 32'd0);
        issue(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h0000_3038);
        collect(0, rd, er);
        check("postrst_ld20", rd, 32'h0);
        issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0000_303C);
        collect(0, rd, er);
        check("postrst_ld10", rd, 32'h0);

        // LATENCY=1: preload, then back-to-back loads
        issue(1, 1'b1, 32'h0000_0000, 32'h1111_1111, 4'hF, 32'h0000_4000);
        collect(1, rd, er);
        issue(1, 1'b1, 32'h0000_0004, 32'h2222_2222, 4'hF, 32'h0000_4004);
        collect(1, rd, er);
        issue(1, 1'b1, 32'h0000_0008, 32'h3333_3333, 4'hF, 32'h0000_4008);
        collect(1, rd, er);

        b2b_addr = '{32'h0, 32'h4, 32'h8, 32'h10};
        b2b_exp  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0};
        resp_ready[1] = 1'b1;
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = b2b_addr[0];
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 10 && !req_ready[1]; i++) @(negedge clk);
            acc[j] = edge_n;
            @(negedge clk);
            check("b2b_valid", 32'(resp_valid[1]), 32'd1);
            check("b2b_rdata", resp_rdata[1],      b2b_exp[j]);
            if (j < 3) req_addr[1] = b2b_addr[j+1];
            else       req_valid[1] = 1'b0;
            if (j > 0) check("b2b_interval", 32'(acc[j] - acc[j-1]), 32'd2);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
